// File: rtl/poly_mul_pkg.sv
// rtl/poly_mul_pkg.sv - command/done codes, enums and step table for the polymul sequencer
package poly_mul_pkg;

    // Command codes driven onto the core's conf bus
    localparam logic [7:0] CONF_IDLE  = 8'd0;
    localparam logic [7:0] CONF_NTT_A = 8'd1;
    localparam logic [7:0] CONF_NTT_B = 8'd3;
    localparam logic [7:0] CONF_PWM   = 8'd4;
    localparam logic [7:0] CONF_INTT  = 8'd5;

    // Completion codes reported by the core on done_flag
    localparam logic [7:0] DONE_NONE  = 8'd0;
    localparam logic [7:0] DONE_NTT   = 8'd1;
    localparam logic [7:0] DONE_PWM   = 8'd2;
    localparam logic [7:0] DONE_INTT  = 8'd3;

    typedef enum logic [1:0] {
        MODE_NTT  = 2'd0,
        MODE_INTT = 2'd1,
        MODE_POLY = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_GAP   = 3'd3,
        S_FIN   = 3'd4,
        S_ERR   = 3'd5
    } state_e;

    // One entry of a mode program: command to issue, code that completes it,
    // and whether it is the final step of the program
    typedef struct packed {
        logic [7:0] code;
        logic [7:0] exp_done;
        logic       last;
    } step_t;

    // Program table: (mode, step) -> {command, expected done code, last}
    function automatic step_t step_entry(input mode_e m, input logic [1:0] s);
        step_t e;
        e = '{code: CONF_IDLE, exp_done: DONE_NONE, last: 1'b1};
        case (m)
            MODE_NTT:  e = '{code: CONF_NTT_A, exp_done: DONE_NTT,  last: 1'b1};
            MODE_INTT: e = '{code: CONF_INTT,  exp_done: DONE_INTT, last: 1'b1};
            MODE_POLY: begin
                case (s)
                    2'd0:    e = '{code: CONF_NTT_A, exp_done: DONE_NTT,  last: 1'b0};
                    2'd1:    e = '{code: CONF_NTT_B, exp_done: DONE_NTT,  last: 1'b0};
                    2'd2:    e = '{code: CONF_PWM,   exp_done: DONE_PWM,  last: 1'b0};
                    default: e = '{code: CONF_INTT,  exp_done: DONE_INTT, last: 1'b1};
                endcase
            end
            default: ;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/step_watchdog.sv
// rtl/step_watchdog.sv - loadable per-step timeout counter with expiry strobe
module step_watchdog
#(
    parameter int TMO_W = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic inc,
    output logic expired
);

    // Count value that the current increment turns into all-ones
    localparam logic [TMO_W-1:0] CNT_LAST = ~TMO_W'(1);
    localparam logic [TMO_W-1:0] CNT_MAX  = '1;

    logic [TMO_W-1:0] cnt;

    // Counter: cleared on load, counts while the step is waiting, saturates at all-ones
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + TMO_W'(1);
        end
    end

    // Fires on the wait cycle that brings the count to all-ones, so a step
    // gets exactly 2^TMO_W-1 wait cycles before it is declared dead
    assign expired = inc && (cnt == CNT_LAST);

endmodule

// File: rtl/poly_mul_sequencer.sv
// rtl/poly_mul_sequencer.sv - steps the polymul core through NTT / PWM / INTT programs
module poly_mul_sequencer
    import poly_mul_pkg::*;
#(
    parameter int CONF_W  = 3,
    parameter int DONE_W  = 3,
    parameter int BATCH_W = 4,
    parameter int GAP_CYC = 1,
    parameter int TMO_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [BATCH_W-1:0] batch,
    input  logic               abort,
    input  logic [DONE_W-1:0]  done_flag,
    output logic [CONF_W-1:0]  conf,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [1:0]         step_idx,
    output logic [BATCH_W-1:0] batch_cnt
);

    // Gap counter terminal value; unused when steps run back-to-back
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYC - 1);

    state_e             state;
    mode_e              mode_q;
    logic [BATCH_W-1:0] batch_q;
    logic [DONE_W-1:0]  exp_q;
    logic               last_q;
    logic               arm;
    logic [15:0]        gap_cnt;

    step_t              start_ent;
    step_t              adv_ent;
    logic [1:0]         adv_step;
    logic [BATCH_W-1:0] batch_next;
    logic               step_hit;
    logic               adv_fin;
    logic               do_adv;
    logic               wd_load;
    logic               wd_inc;
    logic               wd_expired;

    // Next-step lookup, completion detection and advance decision
    always_comb begin
        start_ent  = step_entry(mode_e'(mode), 2'd0);
        adv_step   = last_q ? 2'd0 : step_idx + 2'd1;
        adv_ent    = step_entry(mode_q, adv_step);
        batch_next = batch_cnt + BATCH_W'(1);
        // A flag equal to the expected code only counts once it has been seen
        // to differ during this step, so a stale flag from the previous step
        // carrying the same code cannot complete it
        step_hit   = arm && (done_flag == exp_q);
        adv_fin    = last_q && (batch_next >= batch_q);
        do_adv     = ((state == S_WAIT) && step_hit && (GAP_CYC == 0)) ||
                     ((state == S_GAP) && (gap_cnt == GAP_LAST));
        wd_load    = (state == S_ISSUE);
        wd_inc     = (state == S_WAIT);
    end

    step_watchdog #(
        .TMO_W (TMO_W)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .load    (wd_load),
        .inc     (wd_inc),
        .expired (wd_expired)
    );

    // Sequencer FSM: start/abort, issue, wait for completion, gap, batch advance
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            mode_q    <= MODE_NTT;
            batch_q   <= '0;
            exp_q     <= '0;
            last_q    <= 1'b0;
            arm       <= 1'b0;
            gap_cnt   <= '0;
            conf      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            step_idx  <= '0;
            batch_cnt <= '0;
        end else begin
            done <= 1'b0;
            if (abort && (state != S_IDLE)) begin
                // Cancel wins over everything once a program is running; err is left alone
                state <= S_IDLE;
                conf  <= '0;
                busy  <= 1'b0;
            end else if (do_adv) begin
                if (adv_fin) begin
                    state     <= S_FIN;
                    conf      <= '0;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    batch_cnt <= batch_next;
                end else begin
                    state    <= S_ISSUE;
                    step_idx <= adv_step;
                    conf     <= CONF_W'(adv_ent.code);
                    exp_q    <= DONE_W'(adv_ent.exp_done);
                    last_q   <= adv_ent.last;
                    if (last_q) begin
                        batch_cnt <= batch_next;
                    end
                end
            end else begin
                case (state)
                    S_IDLE, S_ERR: begin
                        if (start) begin
                            if (mode_e'(mode) == MODE_RSVD) begin
                                state <= S_ERR;
                                err   <= 1'b1;
                            end else begin
                                state     <= S_ISSUE;
                                mode_q    <= mode_e'(mode);
                                batch_q   <= (batch == '0) ? BATCH_W'(1) : batch;
                                err       <= 1'b0;
                                step_idx  <= '0;
                                batch_cnt <= '0;
                                conf      <= CONF_W'(start_ent.code);
                                exp_q     <= DONE_W'(start_ent.exp_done);
                                last_q    <= start_ent.last;
                                busy      <= 1'b1;
                            end
                        end
                    end
                    S_ISSUE: begin
                        arm   <= 1'b0;
                        state <= S_WAIT;
                    end
                    S_WAIT: begin
                        // Completion is checked ahead of the watchdog so a
                        // last-moment response still counts
                        if (step_hit) begin
                            conf    <= '0;
                            gap_cnt <= '0;
                            state   <= S_GAP;
                        end else if (wd_expired) begin
                            state <= S_ERR;
                            err   <= 1'b1;
                            conf  <= '0;
                            busy  <= 1'b0;
                        end else if (done_flag != exp_q) begin
                            arm <= 1'b1;
                        end
                    end
                    S_GAP: begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                    S_FIN: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
